p2s_tx: RTL and testbench



---
 rtl/p2s_pkg.sv | 16 +
 rtl/p2s_shift.sv | 32 +++
 rtl/p2s_tx.sv | 144 ++++++++++++++
 tb/tb_p2s_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
// Shared constants and types for the stereo parallel-to-serial transmitter.
package p2s_pkg;

   localparam int P2S_WIDTH = 40;
   localparam int P2S_CNT_W = $clog2(P2S_WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } p2s_state_e;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/p2s_shift.sv
// Single-channel load/shift register; shifts left with zero fill and exposes the MSB.
module p2s_shift
   import p2s_pkg::*;
#(
   parameter int WIDTH = P2S_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_clr_n,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_msb
);

   logic [WIDTH-1:0] r_sh;

   // Load has priority over shift; both are mutually exclusive from the FSM anyway.
   always_ff @(posedge i_clk) begin
      if (!i_clr_n) begin
         r_sh <= {WIDTH{1'b0}};
      end else if (i_load) begin
         r_sh <= i_data;
      end else if (i_shift) begin
         r_sh <= {r_sh[WIDTH-2:0], 1'b0};
      end else begin
         r_sh <= r_sh;
      end
   end

   assign o_msb = r_sh[WIDTH-1];

endmodule

// File: rtl/p2s_tx.sv
// Stereo parallel-to-serial transmitter with a one-pair holding buffer for
// back-to-back frames; FSM, bit counter and handshake live here.
module p2s_tx
   import p2s_pkg::*;
#(
   parameter int WIDTH = P2S_WIDTH
) (
   input  logic             SCLK,
   input  logic             clear_n,
   input  logic             load,
   input  logic [WIDTH-1:0] ParallelL,
   input  logic [WIDTH-1:0] ParallelR,
   output logic             ready,
   output logic             OutputL,
   output logic             OutputR,
   output logic             OutReady,
   output logic             done
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

   p2s_state_e       r_state;
   p2s_state_e       w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0] r_buf_l;
   logic [WIDTH-1:0] r_buf_r;
   logic             r_buf_valid;
   logic             w_buf_valid_nxt;
   logic             w_buf_wr;
   logic             w_sh_load;
   logic             w_sh_shift;
   logic             w_sel_buf;
   logic             w_accept;
   logic             w_last;
   logic             w_msb_l;
   logic             w_msb_r;
   logic [WIDTH-1:0] w_ld_l;
   logic [WIDTH-1:0] w_ld_r;

   assign w_accept = load & ~r_buf_valid;
   assign w_last   = (r_cnt == {CW{1'b0}});
   assign w_ld_l   = w_sel_buf ? r_buf_l : ParallelL;
   assign w_ld_r   = w_sel_buf ? r_buf_r : ParallelR;

   // Next-state, counter and buffer control.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_buf_wr        = 1'b0;
      w_buf_valid_nxt = r_buf_valid;
      w_sh_load       = 1'b0;
      w_sh_shift      = 1'b0;
      w_sel_buf       = 1'b0;
      case (r_state)
         IDLE: begin
            w_buf_valid_nxt = 1'b0;
            if (w_accept) begin
               w_sh_load   = 1'b1;
               w_cnt_nxt   = CNT_TOP;
               w_state_nxt = SHIFT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SHIFT: begin
            if (!w_last) begin
               w_sh_shift = 1'b1;
               w_cnt_nxt  = r_cnt - CW'(1);
               if (w_accept) begin
                  w_buf_wr        = 1'b1;
                  w_buf_valid_nxt = 1'b1;
               end else begin
                  w_buf_wr = 1'b0;
               end
            // Last bit: a buffered pair outranks a fresh one (ready is low then anyway).
            end else if (r_buf_valid) begin
               w_sh_load       = 1'b1;
               w_sel_buf       = 1'b1;
               w_buf_valid_nxt = 1'b0;
               w_cnt_nxt       = CNT_TOP;
            end else if (w_accept) begin
               w_sh_load = 1'b1;
               w_cnt_nxt = CNT_TOP;
            end else begin
               w_sh_shift  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt     = IDLE;
            w_buf_valid_nxt = 1'b0;
         end
      endcase
   end

   // State, counter and holding buffer registers.
   always_ff @(posedge SCLK) begin
      if (!clear_n) begin
         r_state     <= IDLE;
         r_cnt       <= {CW{1'b0}};
         r_buf_valid <= 1'b0;
         r_buf_l     <= {WIDTH{1'b0}};
         r_buf_r     <= {WIDTH{1'b0}};
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_buf_valid <= w_buf_valid_nxt;
         if (w_buf_wr) begin
            r_buf_l <= ParallelL;
            r_buf_r <= ParallelR;
         end else begin
            r_buf_l <= r_buf_l;
            r_buf_r <= r_buf_r;
         end
      end
   end

   p2s_shift #(.WIDTH(WIDTH)) u_shift_l (
      .i_clk   (SCLK),
      .i_clr_n (clear_n),
      .i_load  (w_sh_load),
      .i_shift (w_sh_shift),
      .i_data  (w_ld_l),
      .o_msb   (w_msb_l)
   );

   p2s_shift #(.WIDTH(WIDTH)) u_shift_r (
      .i_clk   (SCLK),
      .i_clr_n (clear_n),
      .i_load  (w_sh_load),
      .i_shift (w_sh_shift),
      .i_data  (w_ld_r),
      .o_msb   (w_msb_r)
   );

   assign ready    = ~r_buf_valid;
   assign OutReady = (r_state == SHIFT);
   assign OutputL  = (r_state == SHIFT) & w_msb_l;
   assign OutputR  = (r_state == SHIFT) & w_msb_r;
   assign done     = (r_state == SHIFT) & w_last;

endmodule

// File: tb/tb_p2s_tx.sv
// Randomized and directed bench for p2s_tx against a frame-level reference model
// plus an end-to-end scoreboard of reassembled words.
module tb_p2s_tx;

   localparam int W = 40;

   logic         SCLK = 1'b0;
   logic         clear_n;
   logic         load;
   logic [W-1:0] ParallelL;
   logic [W-1:0] ParallelR;
   logic         ready;
   logic         OutputL;
   logic         OutputR;
   logic         OutReady;
   logic         done;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: current frame, bit index, holding pair.
   logic         m_act  = 1'b0;
   logic         m_full = 1'b0;
   int           m_i    = 0;
   logic [W-1:0] m_cl, m_cr, m_bl, m_br;
   logic [2*W-1:0] exp_q[$];
   logic [W-1:0] col_l, col_r;
   int           or_cnt, dn_cnt;

   p2s_tx #(.WIDTH(W)) dut (
      .SCLK      (SCLK),
      .clear_n   (clear_n),
      .load      (load),
      .ParallelL (ParallelL),
      .ParallelR (ParallelR),
      .ready     (ready),
      .OutputL   (OutputL),
      .OutputR   (OutputR),
      .OutReady  (OutReady),
      .done      (done)
   );

   always #5 SCLK = ~SCLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_edge(input logic ld, input logic [W-1:0] l, input logic [W-1:0] r,
                             input logic cn);
      logic acc;
      if (!cn) begin
         m_act = 1'b0; m_full = 1'b0; m_i = 0;
         exp_q.delete();
         col_l = '0; col_r = '0;
      end else begin
         acc = ld && !m_full;
         if (acc) exp_q.push_back({l, r});
         if (!m_act) begin
            if (acc) begin m_act = 1'b1; m_cl = l; m_cr = r; m_i = 0; end
         end else if (m_i < W - 1) begin
            m_i++;
            if (acc) begin m_bl = l; m_br = r; m_full = 1'b1; end
         end else if (m_full) begin
            m_cl = m_bl; m_cr = m_br; m_full = 1'b0; m_i = 0;
         end else if (acc) begin
            m_cl = l; m_cr = r; m_i = 0;
         end else begin
            m_act = 1'b0;
         end
      end
   endtask

   task automatic sample();
      logic el, er;
      el = m_act ? m_cl[W-1-m_i] : 1'b0;
      er = m_act ? m_cr[W-1-m_i] : 1'b0;
      check("ready",    64'(ready),    64'(!m_full));
      check("OutReady", 64'(OutReady), 64'(m_act));
      check("OutputL",  64'(OutputL),  64'(el));
      check("OutputR",  64'(OutputR),  64'(er));
      check("done",     64'(done),     64'(m_act && m_i == W - 1));
      if (OutReady === 1'b1) begin
         or_cnt++;
         col_l = {col_l[W-2:0], OutputL};
         col_r = {col_r[W-2:0], OutputR};
      end
      if (done === 1'b1) begin
         dn_cnt++;
         if (exp_q.size() == 0) begin
            check("sb_extra_frame", 64'd1, 64'd0);
         end else begin
            check("frame_L", 64'(col_l), 64'(exp_q[0][2*W-1:W]));
            check("frame_R", 64'(col_r), 64'(exp_q[0][W-1:0]));
            void'(exp_q.pop_front());
         end
      end
   endtask

   // One clock: drive at negedge, advance model, sample at the following negedge.
   task automatic cyc(input logic ld, input logic [W-1:0] l, input logic [W-1:0] r,
                      input logic cn);
      load = ld; ParallelL = l; ParallelR = r; clear_n = cn;
      model_edge(ld, l, r, cn);
      @(posedge SCLK);
      @(negedge SCLK);
      sample();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, $urandom, $urandom, 1'b1);
   endtask

   initial begin
      logic [63:0] rl, rr;
      clear_n = 1'b0; load = 1'b0; ParallelL = '0; ParallelR = '0;
      col_l = '0; col_r = '0;
      @(negedge SCLK);

      // Reset and idle
      repeat (3) cyc(1'b0, '0, '0, 1'b0);
      idle(5);

      // Single frame
      or_cnt = 0; dn_cnt = 0;
      cyc(1'b1, 40'h80_0000_0001, 40'h00_0000_0002, 1'b1);
      idle(45);
      check("single_or_cycles", 64'(or_cnt), 64'd40);
      check("single_done_cnt",  64'(dn_cnt), 64'd1);

      // Back-to-back: second pair loaded during bit 10 of the first frame
      or_cnt = 0; dn_cnt = 0;
      cyc(1'b1, 40'h80_0000_0001, 40'h00_0000_0002, 1'b1);
      idle(10);
      cyc(1'b1, 40'hFF_FFFF_FFFF, 40'h00_0000_0000, 1'b1);
      idle(80);
      check("b2b_or_cycles", 64'(or_cnt), 64'd80);
      check("b2b_done_cnt",  64'(dn_cnt), 64'd2);

      // Load exactly on the last-bit cycle with the buffer empty
      cyc(1'b1, 40'h12_0000_0034, 40'h56_0000_0078, 1'b1);
      idle(W - 1);
      cyc(1'b1, 40'hA5_A5A5_A5A5, 40'h5A_5A5A_5A5A, 1'b1);
      check("done_load_msb", 64'(OutputL), 64'd1);
      idle(45);

      // Overflow while the buffer is full is ignored
      cyc(1'b1, 40'h01_0203_0405, 40'h06_0708_090A, 1'b1);
      idle(5);
      cyc(1'b1, 40'hC3_C3C3_C3C3, 40'h3C_3C3C_3C3C, 1'b1);
      idle(3);
      cyc(1'b1, 40'h12_3456_789A, 40'h12_3456_789A, 1'b1);
      idle(85);

      // Reset mid-frame with the buffer full
      cyc(1'b1, 40'hF0_F0F0_F0F0, 40'h0F_0F0F_0F0F, 1'b1);
      idle(5);
      cyc(1'b1, 40'hAA_AAAA_AAAA, 40'h55_5555_5555, 1'b1);
      idle(13);
      cyc(1'b0, '0, '0, 1'b0);
      check("rst_mid_ready",    64'(ready),    64'd1);
      check("rst_mid_outready", 64'(OutReady), 64'd0);
      or_cnt = 0;
      idle(90);
      check("rst_mid_no_bits", 64'(or_cnt), 64'd0);

      // Randomized traffic with occasional resets
      for (int k = 0; k < 4000; k++) begin
         rl = {$urandom, $urandom};
         rr = {$urandom, $urandom};
         cyc(($urandom_range(0, 99) < 35), rl[W-1:0], rr[W-1:0],
             ($urandom_range(0, 599) != 0));
      end
      idle(90);
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
